ins_scheduler: RTL

//  Multi-cycle instruction sequencer for the conv/maxpool/ReLU engine. It fetches instruction words from

---
 rtl/ins_scheduler.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ins_scheduler.sv
// Handshake-driven instruction sequencer for the conv/maxpool/ReLU engine.
// Fetches, decodes and issues work to fetch/writeback units, with watchdog.
`timescale 1ns/1ps
module ins_scheduler #(
  parameter int INS_ADDR_WIDTH = 10,
  parameter int ADDR_WIDTH     = 10,
  parameter int IMG_SIZE_WIDTH = 5,
  parameter int OPCODE_WIDTH   = 3,
  parameter int TIMEOUT_WIDTH  = 12,
  localparam int INS_W = OPCODE_WIDTH + 3*ADDR_WIDTH + IMG_SIZE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  output logic [INS_ADDR_WIDTH-1:0] ins_addr,
  input  logic [INS_W-1:0]          ins_rdata,
  output logic                      img_start,
  output logic [ADDR_WIDTH-1:0]     img_addr,
  output logic [IMG_SIZE_WIDTH-1:0] img_size,
  input  logic                      img_done,
  output logic                      ker_start,
  output logic [ADDR_WIDTH-1:0]     ker_addr,
  output logic [2:0]                ker_size,
  input  logic                      ker_done,
  output logic                      wb_start,
  output logic [ADDR_WIDTH-1:0]     out_addr,
  output logic [1:0]                pe_op,
  input  logic                      wb_done,
  output logic                      busy,
  output logic                      halted,
  output logic                      err_timeout,
  output logic                      err_illegal,
  output logic [15:0]               ins_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_NEXT   = 3'd6;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [OPCODE_WIDTH-1:0] OP_CONV2 = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_CONV3 = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_CONV5 = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_MAXP  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_RELU  = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_ILL   = OPCODE_WIDTH'(7);

  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST =
    {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

  logic [2:0]                state_q, state_d;
  logic [INS_ADDR_WIDTH-1:0] ia_q, ia_d;
  logic [ADDR_WIDTH-1:0]     img_a_q, img_a_d;
  logic [ADDR_WIDTH-1:0]     ker_a_q, ker_a_d;
  logic [ADDR_WIDTH-1:0]     out_a_q, out_a_d;
  logic [IMG_SIZE_WIDTH-1:0] isz_q, isz_d;
  logic [2:0]                ksz_q, ksz_d;
  logic [1:0]                pe_q, pe_d;
  logic                      ken_q, ken_d;
  logic                      iseen_q, iseen_d;
  logic                      kseen_q, kseen_d;
  logic [TIMEOUT_WIDTH-1:0]  wd_q, wd_d;
  logic                      eto_q, eto_d;
  logic                      eil_q, eil_d;
  logic [15:0]               cnt_q, cnt_d;

  logic [OPCODE_WIDTH-1:0] op;
  logic [1:0]              dec_pe;
  logic [2:0]              dec_ks;
  logic                    dec_ken;
  logic                    dec_exec;
  logic                    dec_halt;
  logic                    dec_ill;

  assign op = ins_rdata[OPCODE_WIDTH-1:0];

  always_comb begin
    dec_pe   = 2'b00;
    dec_ks   = 3'd0;
    dec_ken  = 1'b0;
    dec_exec = 1'b0;
    dec_halt = 1'b0;
    dec_ill  = 1'b0;
    unique case (op)
      OP_CONV2: begin
        dec_pe = 2'b01; dec_ks = 3'd2;
        dec_ken = 1'b1; dec_exec = 1'b1;
      end
      OP_CONV3: begin
        dec_pe = 2'b01; dec_ks = 3'd3;
        dec_ken = 1'b1; dec_exec = 1'b1;
      end
      OP_CONV5: begin
        dec_pe = 2'b01; dec_ks = 3'd5;
        dec_ken = 1'b1; dec_exec = 1'b1;
      end
      OP_MAXP: begin
        dec_pe = 2'b10; dec_ks = 3'd2;
        dec_exec = 1'b1;
      end
      OP_RELU: begin
        dec_pe = 2'b11; dec_exec = 1'b1;
      end
      OP_HALT: dec_halt = 1'b1;
      OP_ILL:  dec_ill  = 1'b1;
      default: ;
    endcase
  end

  // Watchdog defaults to zero so it clears on every state change.
  always_comb begin
    state_d = state_q;
    ia_d    = ia_q;
    img_a_d = img_a_q;
    ker_a_d = ker_a_q;
    out_a_d = out_a_q;
    isz_d   = isz_q;
    ksz_d   = ksz_q;
    pe_d    = pe_q;
    ken_d   = ken_q;
    iseen_d = iseen_q;
    kseen_d = kseen_q;
    wd_d    = '0;
    eto_d   = eto_q;
    eil_d   = eil_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          ia_d    = '0;
          eto_d   = 1'b0;
          eil_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        out_a_d = ins_rdata[OPCODE_WIDTH +: ADDR_WIDTH];
        ker_a_d = ins_rdata[OPCODE_WIDTH+ADDR_WIDTH +: ADDR_WIDTH];
        img_a_d = ins_rdata[OPCODE_WIDTH+2*ADDR_WIDTH +: ADDR_WIDTH];
        isz_d   = ins_rdata[OPCODE_WIDTH+3*ADDR_WIDTH +: IMG_SIZE_WIDTH];
        pe_d    = dec_pe;
        ksz_d   = dec_ks;
        ken_d   = dec_ken;
        if (dec_ill) eil_d = 1'b1;
        if (dec_halt)      state_d = S_HALT;
        else if (dec_exec) state_d = S_ISSUE;
        else               state_d = S_NEXT;
      end
      S_ISSUE: begin
        iseen_d = 1'b0;
        kseen_d = !ken_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        iseen_d = iseen_q | img_done;
        kseen_d = kseen_q | ker_done;
        if (iseen_d && kseen_d) begin
          state_d = S_WB;
        end else if (wd_q == WD_LAST) begin
          eto_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_WB: begin
        if (wd_q != '0 && wb_done) begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          state_d = S_NEXT;
        end else if (wd_q == WD_LAST) begin
          eto_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (&ia_q) begin
          state_d = S_HALT;
        end else begin
          ia_d    = ia_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      ia_q    <= '0;
      img_a_q <= '0;
      ker_a_q <= '0;
      out_a_q <= '0;
      isz_q   <= '0;
      ksz_q   <= '0;
      pe_q    <= '0;
      ken_q   <= 1'b0;
      iseen_q <= 1'b0;
      kseen_q <= 1'b0;
      wd_q    <= '0;
      eto_q   <= 1'b0;
      eil_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ia_q    <= ia_d;
      img_a_q <= img_a_d;
      ker_a_q <= ker_a_d;
      out_a_q <= out_a_d;
      isz_q   <= isz_d;
      ksz_q   <= ksz_d;
      pe_q    <= pe_d;
      ken_q   <= ken_d;
      iseen_q <= iseen_d;
      kseen_q <= kseen_d;
      wd_q    <= wd_d;
      eto_q   <= eto_d;
      eil_q   <= eil_d;
      cnt_q   <= cnt_d;
    end
  end

  // First WB cycle is the only one with a zero watchdog.
  assign wb_start    = (state_q == S_WB) && (wd_q == '0);
  assign img_start   = (state_q == S_ISSUE);
  assign ker_start   = (state_q == S_ISSUE) && ken_q;
  assign ins_addr    = ia_q;
  assign img_addr    = img_a_q;
  assign img_size    = isz_q;
  assign ker_addr    = ker_a_q;
  assign ker_size    = ksz_q;
  assign out_addr    = out_a_q;
  assign pe_op       = pe_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted      = (state_q == S_HALT);
  assign err_timeout = eto_q;
  assign err_illegal = eil_q;
  assign ins_count   = cnt_q;

endmodule
